// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with in-place CSRRW/CSRRS/CSRRC, 2*XLEN
// cycle/instret counters with inhibit, interrupt sampling and the MIE/MPIE
// trap-entry / mret stack.
module csr_unit #(
  parameter int              XLEN      = 16,
  parameter logic [XLEN-1:0] MTVEC_RST = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      ex_op,
  input  logic [11:0]     ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            ex_src_zero,
  output logic [XLEN-1:0] ex_rdata,
  output logic            ex_illegal,
  input  logic            retire,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  input  logic            trap_valid,
  input  logic            trap_is_int,
  input  logic [3:0]      trap_code,
  input  logic [XLEN-1:0] trap_epc,
  input  logic            mret,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] csr_mepc,
  output logic            global_int_en,
  output logic            int_req,
  output logic [3:0]      int_code
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MCNTINH  = 12'h320;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTR   = 12'hB02;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_INSTR    = 12'hC02;
  localparam logic [11:0] A_INSTRH   = 12'hC82;

  localparam logic [2*XLEN-1:0] CNT_ONE  = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   BIT0_CLR = ~{{(XLEN-1){1'b0}}, 1'b1};

  // Place three flags at bit positions 11, 7 and 3 (mstatus/mie/mip layout).
  function automatic logic [XLEN-1:0] bits_11_7_3(input logic b11, input logic b7, input logic b3);
    logic [XLEN-1:0] v;
    v     = {XLEN{1'b0}};
    v[11] = b11;
    v[7]  = b7;
    v[3]  = b3;
    return v;
  endfunction

  // State: interrupt-type vectors are ordered {external, timer, software}.
  logic                mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [2:0]          mie_q, mie_d, mip_q, mip_d;
  logic [XLEN-1:0]     mtvec_q, mtvec_d, mepc_q, mepc_d, mscratch_q, mscratch_d;
  logic                mcause_int_q, mcause_int_d;
  logic [3:0]          mcause_code_q, mcause_code_d;
  logic                cy_inh_q, cy_inh_d, ir_inh_q, ir_inh_d;
  logic [2*XLEN-1:0]   mcycle_q, mcycle_d, minstret_q, minstret_d;

  logic [XLEN-1:0]     rd_s, wval_s, tvec_base_s;
  logic                mapped_s, wr_req_s, ro_s, illegal_s, we_s;
  logic [2:0]          pend_s;

  // Read mux: pre-write value of the addressed CSR and whether it exists.
  always_comb begin
    rd_s     = {XLEN{1'b0}};
    mapped_s = 1'b1;
    case (ex_addr)
      A_MSTATUS:           rd_s = bits_11_7_3(1'b0, mst_mpie_q, mst_mie_q);
      A_MIE:               rd_s = bits_11_7_3(mie_q[2], mie_q[1], mie_q[0]);
      A_MTVEC:             rd_s = mtvec_q;
      A_MCNTINH:           rd_s = {{(XLEN-3){1'b0}}, ir_inh_q, 1'b0, cy_inh_q};
      A_MSCRATCH:          rd_s = mscratch_q;
      A_MEPC:              rd_s = mepc_q;
      A_MCAUSE:            rd_s = {mcause_int_q, {(XLEN-5){1'b0}}, mcause_code_q};
      A_MIP:               rd_s = bits_11_7_3(mip_q[2], mip_q[1], mip_q[0]);
      A_MCYCLE, A_CYCLE:   rd_s = mcycle_q[XLEN-1:0];
      A_MCYCLEH, A_CYCLEH: rd_s = mcycle_q[2*XLEN-1:XLEN];
      A_MINSTR, A_INSTR:   rd_s = minstret_q[XLEN-1:0];
      A_MINSTRH, A_INSTRH: rd_s = minstret_q[2*XLEN-1:XLEN];
      default:             mapped_s = 1'b0;
    endcase
  end

  // Access decode and read-modify-write value computation.
  always_comb begin
    wr_req_s  = (ex_op != 2'b00) && !(ex_op[1] && ex_src_zero);
    ro_s      = (ex_addr == A_MIP) || (ex_addr[11:8] == 4'hC);
    illegal_s = (ex_op != 2'b00) && (!mapped_s || (wr_req_s && ro_s));
    we_s      = wr_req_s && !illegal_s;
    case (ex_op)
      2'b01:   wval_s = ex_wdata;
      2'b10:   wval_s = rd_s | ex_wdata;
      2'b11:   wval_s = rd_s & ~ex_wdata;
      default: wval_s = rd_s;
    endcase
  end

  assign ex_rdata   = illegal_s ? {XLEN{1'b0}} : rd_s;
  assign ex_illegal = illegal_s;

  // Next state: counters, then EX write, then mret/trap override the
  // registers they own so the higher-priority source wins on collisions.
  always_comb begin
    mst_mie_d     = mst_mie_q;
    mst_mpie_d    = mst_mpie_q;
    mie_d         = mie_q;
    mip_d         = {irq_ext, irq_timer, irq_soft};
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mscratch_d    = mscratch_q;
    mcause_int_d  = mcause_int_q;
    mcause_code_d = mcause_code_q;
    cy_inh_d      = cy_inh_q;
    ir_inh_d      = ir_inh_q;
    mcycle_d      = cy_inh_q ? mcycle_q : mcycle_q + CNT_ONE;
    minstret_d    = (retire && !ir_inh_q) ? minstret_q + CNT_ONE : minstret_q;
    if (we_s) begin
      case (ex_addr)
        A_MSTATUS:  begin mst_mie_d = wval_s[3]; mst_mpie_d = wval_s[7]; end
        A_MIE:      mie_d = {wval_s[11], wval_s[7], wval_s[3]};
        A_MTVEC:    mtvec_d = wval_s;
        A_MCNTINH:  begin cy_inh_d = wval_s[0]; ir_inh_d = wval_s[2]; end
        A_MSCRATCH: mscratch_d = wval_s;
        A_MEPC:     mepc_d = wval_s & BIT0_CLR;
        A_MCAUSE:   begin mcause_int_d = wval_s[XLEN-1]; mcause_code_d = wval_s[3:0]; end
        A_MCYCLE:   mcycle_d = {mcycle_q[2*XLEN-1:XLEN], wval_s};
        A_MCYCLEH:  mcycle_d = {wval_s, mcycle_q[XLEN-1:0]};
        A_MINSTR:   minstret_d = {minstret_q[2*XLEN-1:XLEN], wval_s};
        A_MINSTRH:  minstret_d = {wval_s, minstret_q[XLEN-1:0]};
        default:    mtvec_d = mtvec_q;
      endcase
    end else begin
      mtvec_d = mtvec_q;
    end
    if (trap_valid) begin
      mepc_d        = trap_epc & BIT0_CLR;
      mcause_int_d  = trap_is_int;
      mcause_code_d = trap_code;
      mst_mpie_d    = mst_mie_q;
      mst_mie_d     = 1'b0;
    end else if (mret) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else begin
      mst_mie_d  = mst_mie_d;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_mie_q     <= 1'b0;
      mst_mpie_q    <= 1'b0;
      mie_q         <= 3'b000;
      mip_q         <= 3'b000;
      mtvec_q       <= MTVEC_RST;
      mepc_q        <= {XLEN{1'b0}};
      mscratch_q    <= {XLEN{1'b0}};
      mcause_int_q  <= 1'b0;
      mcause_code_q <= 4'd0;
      cy_inh_q      <= 1'b0;
      ir_inh_q      <= 1'b0;
      mcycle_q      <= {(2*XLEN){1'b0}};
      minstret_q    <= {(2*XLEN){1'b0}};
    end else begin
      mst_mie_q     <= mst_mie_d;
      mst_mpie_q    <= mst_mpie_d;
      mie_q         <= mie_d;
      mip_q         <= mip_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mscratch_q    <= mscratch_d;
      mcause_int_q  <= mcause_int_d;
      mcause_code_q <= mcause_code_d;
      cy_inh_q      <= cy_inh_d;
      ir_inh_q      <= ir_inh_d;
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
    end
  end

  // Handler target: vectored mode offsets interrupts by 4*cause.
  always_comb begin
    tvec_base_s = {mtvec_q[XLEN-1:2], 2'b00};
    if ((mtvec_q[1:0] == 2'b01) && trap_is_int) begin
      trap_pc = tvec_base_s + {{(XLEN-6){1'b0}}, trap_code, 2'b00};
    end else begin
      trap_pc = tvec_base_s;
    end
  end

  // Interrupt request and fixed priority: external > software > timer.
  always_comb begin
    pend_s   = mip_q & mie_q;
    int_req  = mst_mie_q && (pend_s != 3'b000);
    int_code = 4'd0;
    if (int_req) begin
      if (pend_s[2])      int_code = 4'd11;
      else if (pend_s[0]) int_code = 4'd3;
      else if (pend_s[1]) int_code = 4'd7;
      else                int_code = 4'd0;
    end else begin
      int_code = 4'd0;
    end
  end

  assign csr_mepc      = mepc_q;
  assign global_int_en = mst_mie_q;

endmodule

// File: doc/csr_unit.md
# csr_unit

Parametrised machine-mode CSR file for the pipelined core, successor to the fixed 16-bit CSR block. It performs CSRRW/CSRRS/CSRRC read-modify-write internally and keeps 2·XLEN-bit cycle and instret counters with an inhibit control. It samples external, timer and software interrupt lines into mip and owns the mstatus MIE/MPIE stack for trap entry and mret. It sits beside EX: EX supplies CSR accesses and retire pulses, and the interrupt controller drives trap entry and exit.

## Interface
- XLEN, 16: data width. XLEN ≥ 16 is required because mip/mie bit 11 must exist.
- MTVEC_RST, 0: reset value of mtvec.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_op  in  2  CSR operation: 00 none, 01 RW, 10 RS (set), 11 RC (clear).
- ex_addr  in  12  CSR address.
- ex_wdata  in  XLEN  source operand.
- ex_src_zero  in  1  source is x0/zero-immediate. When set with RS/RC, no write occurs.
- ex_rdata  out  XLEN  old CSR value (combinational).
- ex_illegal  out  1  access is illegal (combinational).
- retire  in  1  one instruction retired this cycle.
- irq_ext, irq_timer, irq_soft  in  1 each  level-sensitive interrupt lines.
- trap_valid  in  1  trap entry pulse.
- trap_is_int  in  1  the trap is an interrupt.
- trap_code  in  4  cause code.
- trap_epc  in  XLEN  pc to save.
- mret  in  1  trap return pulse.
- trap_pc  out  XLEN  handler target.
- csr_mepc  out  XLEN  mepc, used as the mret target.
- global_int_en  out  1  mstatus.MIE.
- int_req  out  1  an enabled interrupt is pending.
- int_code  out  4  code of the highest-priority pending interrupt.

## Operation
- Registers, all reset to 0 except mtvec, which resets to MTVEC_RST:
  - mstatus: only bit 3 (MIE) and bit 7 (MPIE) are implemented. Other bits read 0.
  - mie: only bits 3, 7 and 11 are implemented.
  - mip: read-only. Bit 11 = registered irq_ext, bit 7 = registered irq_timer, bit 3 = registered irq_soft. Loaded every cycle.
  - mtvec, mepc, mscratch: full width. mepc bit 0 always reads 0.
  - mcause: bit XLEN-1 = interrupt flag, bits 3:0 = code. Other bits read 0.
  - mcountinhibit: bit 0 = CY, bit 2 = IR.
  - mcycle and minstret: 2·XLEN bits each.
- Addresses (standard RISC-V numbering):
  - 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x320 mcountinhibit, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x344 mip.
  - 0xB00/0xB80 mcycle low/high, 0xB02/0xB82 minstret low/high.
  - 0xC00/0xC80 cycle, 0xC02/0xC82 instret: read-only aliases.
- Write value: RW gives wdata, RS gives old | wdata, RC gives old & ~wdata.
- A write occurs when ex_op≠00, except when the op is RS/RC with ex_src_zero set.
- Illegal access: the address is unmapped, or a write is attempted to mip or 0xC**. The CSR state is not changed and ex_rdata = 0.
- Read forwarding: if a CSR is written this cycle, ex_rdata still returns the pre-write (old) value. This is required for RMW semantics.
- Counters:
  - mcycle increments each cycle unless CY is set.
  - minstret increments on retire unless IR is set.
  - A software write to either half replaces that half. That cycle's increment for that counter is dropped.
  - Counters wrap from all-ones to 0.
- Trap entry (trap_valid):
  - mepc ← trap_epc with bit 0 cleared.
  - mcause ← {trap_is_int, code}.
  - MPIE ← MIE, MIE ← 0.
- mret: MIE ← MPIE, MPIE ← 1.
- Priority within one cycle: trap_valid > mret > EX write.
  - A lower-priority update that collides on the same register is dropped.
  - EX writes to other registers still occur.
  - trap_valid with mret set in the same cycle: mret is ignored.
- trap_pc:
  - mtvec[1:0]=01 (vectored) and trap_is_int: trap_pc = {mtvec[XLEN-1:2],2'b00} + 4·trap_code.
  - Otherwise: trap_pc = {mtvec[XLEN-1:2],2'b00}.
  - Mode values 10 and 11 behave as direct.
- int_req = MIE & |(mip & mie).
- int_code priority: external 11 > software 3 > timer 7. int_code is 0 when int_req=0.

## Timing
- Writes and trap/mret updates become visible on the next rising edge.
- irq_* to mip: one cycle. int_req asserts in the same cycle mip sets, provided it is enabled.
- ex_rdata, ex_illegal, trap_pc and int_req/int_code are combinational from current state and inputs. There is no handshake.
- rst asserted at any time returns all state to reset values immediately. An in-flight trap or write is lost.
- First counter increment occurs on the first edge after rst deasserts, so mcycle reads 1 one cycle after release.

## Test plan
- Reset, then read 0x305 → MTVEC_RST. Read 0x300, 0x341, 0x342, 0xB00 → 0 during reset.
- CSRRS 0x300 with wdata 0x0008 → ex_rdata 0 that cycle, then 0x0008. CSRRC with ex_src_zero=1 → no change.
- mie=0x0888, MIE=1, raise irq_timer and irq_ext → int_req after 1 cycle, int_code 11. Drop irq_ext → int_code 7.
- trap_valid with is_int=1, code 7, epc 0x0123, mtvec 0x0101 → mepc 0x0122, mcause 0x8007, trap_pc 0x011C, MIE 0, MPIE 1. Then mret → MIE 1.
- Write 0xFFFF to 0xB00 and 0 to 0xB80 → next cycle mcycle wraps low half to 0, high half to 1. Set CY → counter frozen.
- Write to 0xC00, 0x344 or 0x7FF → ex_illegal=1, ex_rdata 0, no state change. trap_valid colliding with an EX write to mepc → trap value wins.
